// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops plus iterative
// shift-add multiply and restoring divide, with valid/ready on both sides.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       f,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div0,
  output logic             busy
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;
  localparam logic [4:0] OP_NOR  = 5'b01010;
  localparam logic [4:0] OP_SLLV = 5'b01011;
  localparam logic [4:0] OP_SRLV = 5'b01100;
  localparam logic [4:0] OP_SRAV = 5'b01101;
  localparam logic [4:0] OP_LUI  = 5'b01110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 zero_q, zero_d;
  logic                 div0_q, div0_d;

  logic                 accept;
  logic                 last;
  logic                 op_signed;
  logic [WIDTH-1:0]     sc_res;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   mul_res;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_res;
  logic [WIDTH-1:0]     rem_res;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign in_ready  = rst_n && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign y         = y_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign div0      = div0_q;
  assign last      = (cnt_q == SHW'(WIDTH - 1));
  assign op_signed = ~f[0];

  // Multiply: acc holds {partial high, remaining multiplier bits}; one add-shift per cycle.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = neg_lo_q ? -mul_next : mul_next;

  // Divide: acc holds {remainder, dividend/quotient}; one trial subtract per cycle.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo_res   = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_res   = neg_hi_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

  always_comb begin
    sc_res = '0;
    case (f)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLL:  sc_res = b << shamt;
      OP_SRL:  sc_res = b >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(b) >>> shamt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_NOR:  sc_res = ~(a | b);
      OP_SLLV: sc_res = b << a[SHW-1:0];
      OP_SRLV: sc_res = b >> a[SHW-1:0];
      OP_SRAV: sc_res = $unsigned($signed(b) >>> a[SHW-1:0]);
      OP_LUI:  sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    y_d      = y_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    div0_d   = div0_q;

    case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + SHW'(1);
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          y_d     = mul_res[WIDTH-1:0];
          hi_d    = mul_res[2*WIDTH-1:WIDTH];
          zero_d  = (mul_res[WIDTH-1:0] == '0);
          div0_d  = 1'b0;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + SHW'(1);
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          // Divide by zero still runs the full iteration count so latency stays fixed.
          if (dz_q) begin
            y_d    = '1;
            hi_d   = a_q;
            div0_d = 1'b1;
          end else begin
            y_d    = quo_res;
            hi_d   = rem_res;
            div0_d = 1'b0;
          end
          zero_d = (y_d == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      div0_d = 1'b0;
      cnt_d  = '0;
      a_d    = a;
      if (f[4:2] == 3'b100) begin
        opnd_d   = mag(b, op_signed);
        acc_d    = {{WIDTH{1'b0}}, mag(a, op_signed)};
        neg_lo_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_hi_d = op_signed & a[WIDTH-1];
        dz_d     = (b == '0);
        state_d  = f[1] ? S_DIV : S_MUL;
      end else begin
        y_d     = sc_res;
        hi_d    = '0;
        zero_d  = (sc_res == '0);
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      y_q      <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      y_q      <= y_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, handshake/reset sequences and
// random operations checked against a plain-arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   f = '0;
  logic [4:0]   shamt = '0;
  logic         in_ready, out_valid, zero, div0, busy;
  logic [W-1:0] y, hi;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  f;
    logic [4:0]  sh;
    logic [31:0] y;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  vec_t        vecs[$];
  logic [4:0]  codes[22];
  logic [31:0] tp_a[4], tp_b[4], tp_y[4], tp_hi[4];
  logic [4:0]  tp_f[4], tp_sh[4];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .hi(hi), .zero(zero), .div0(div0), .busy(busy)
  );

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", nm, got, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference: what each op means arithmetically, using 64-bit integers.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                input logic [4:0] mf, input logic [4:0] msh,
                                output logic [31:0] my, output logic [31:0] mhi,
                                output logic mdz);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'h0, ma};
    ub = {32'h0, mb};
    my = '0; mhi = '0; mdz = 1'b0; p = '0;
    case (mf)
      5'd0:  my = ma + mb;
      5'd1:  my = ma - mb;
      5'd2:  my = ma & mb;
      5'd3:  my = ma | mb;
      5'd4:  my = ma ^ mb;
      5'd5:  my = mb << msh;
      5'd6:  my = mb >> msh;
      5'd7:  my = $unsigned($signed(mb) >>> msh);
      5'd8:  my = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  my = (ua < ub) ? 32'd1 : 32'd0;
      5'd10: my = ~(ma | mb);
      5'd11: my = mb << ma[4:0];
      5'd12: my = mb >> ma[4:0];
      5'd13: my = $unsigned($signed(mb) >>> ma[4:0]);
      5'd14: my = {mb[15:0], 16'h0};
      5'd16: begin p = sa * sb; my = p[31:0]; mhi = p[63:32]; end
      5'd17: begin p = ua * ub; my = p[31:0]; mhi = p[63:32]; end
      5'd18: begin
        if (mb == 32'h0) begin my = '1; mhi = ma; mdz = 1'b1; end
        else begin my = 32'(sa / sb); mhi = 32'(sa % sb); end
      end
      5'd19: begin
        if (mb == 32'h0) begin my = '1; mhi = ma; mdz = 1'b1; end
        else begin my = 32'(ua / ub); mhi = 32'(ua % ub); end
      end
      default: begin my = '0; mhi = '0; end
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [31:0] va, input logic [31:0] vb,
                        input logic [4:0] vf, input logic [4:0] vsh,
                        input logic [31:0] ey, input logic [31:0] ehi, input logic edz);
    int n, lat;
    bit busy_ok, multi;
    multi = (vf[4:2] == 3'b100);
    @(negedge clk);
    a = va; b = vb; f = vf; shamt = vsh; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1({nm, ".accept"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; f = 5'($urandom); shamt = 5'($urandom);
    @(negedge clk);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk32({nm, ".latency"}, 32'(lat), multi ? 32'(W) : 32'd0);
    if (multi) begin
      chk1({nm, ".busy_during"}, busy_ok, 1'b1);
      chk1({nm, ".busy_after"}, busy, 1'b0);
    end
    chk32({nm, ".y"}, y, ey);
    chk32({nm, ".hi"}, hi, ehi);
    chk1({nm, ".zero"}, zero, (ey == 32'h0));
    chk1({nm, ".div0"}, div0, edz);
    $display("op %s f=%b a=%h b=%h sh=%0d -> y=%h hi=%h zero=%b div0=%b lat=%0d",
             nm, vf, va, vb, vsh, y, hi, zero, div0, lat);
  endtask

  initial begin
    logic [31:0] ry, rhi, ra, rb;
    logic [4:0]  rf, rsh;
    logic        rdz, seen_valid;

    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 5'b00000, 5'd0,  32'h00000000, 32'h0, 1'b0});
    vecs.push_back('{32'h00000024, 32'h80000000, 5'b01101, 5'd0,  32'hF8000000, 32'h0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h1234ABCD, 5'b01110, 5'd0,  32'hABCD0000, 32'h0, 1'b0});
    vecs.push_back('{32'hFFFFFFFD, 32'h00000007, 5'b10000, 5'd0,  32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10001, 5'd0,  32'h00000001, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{32'hFFFFFFF9, 32'h00000002, 5'b10010, 5'd0,  32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'h00000005, 32'h00000000, 5'b10011, 5'd0,  32'hFFFFFFFF, 32'h00000005, 1'b1});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 5'b10010, 5'd0,  32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h00000005, 32'h00000007, 5'b00001, 5'd0,  32'hFFFFFFFE, 32'h0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 5'b01000, 5'd0,  32'h00000001, 32'h0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 5'b01001, 5'd0,  32'h00000000, 32'h0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000000, 5'b01010, 5'd0,  32'hFFFFFFFF, 32'h0, 1'b0});
    vecs.push_back('{32'h00000005, 32'h00000006, 5'b01111, 5'd0,  32'h00000000, 32'h0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000001, 5'b00101, 5'd31, 32'h80000000, 32'h0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h80000000, 5'b00111, 5'd4,  32'hF8000000, 32'h0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h80000000, 5'b00110, 5'd4,  32'h08000000, 32'h0, 1'b0});
    vecs.push_back('{32'hFFFFFFFB, 32'h00000000, 5'b10010, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1});
    vecs.push_back('{32'hFFFFFFE3, 32'h00000001, 5'b01011, 5'd0,  32'h00000008, 32'h0, 1'b0});
    vecs.push_back('{32'h00000021, 32'h00000010, 5'b01100, 5'd0,  32'h00000008, 32'h0, 1'b0});
    vecs.push_back('{32'h00000064, 32'h00000007, 5'b10011, 5'd0,  32'h0000000E, 32'h00000002, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 5'b10000, 5'd0,  32'h00000000, 32'h40000000, 1'b0});
    vecs.push_back('{32'h00000007, 32'hFFFFFFFE, 5'b10010, 5'd0,  32'hFFFFFFFD, 32'h00000001, 1'b0});
    vecs.push_back('{32'hFF00FF00, 32'h0F0F0F0F, 5'b00010, 5'd0,  32'h0F000F00, 32'h0, 1'b0});
    vecs.push_back('{32'h000000F0, 32'h0000000F, 5'b00011, 5'd0,  32'h000000FF, 32'h0, 1'b0});
    vecs.push_back('{32'hFFFF0000, 32'h0FF00FF0, 5'b00100, 5'd0,  32'hF00F0FF0, 32'h0, 1'b0});

    for (int i = 0; i < 20; i++) codes[i] = 5'(i);
    codes[20] = 5'd20;
    codes[21] = 5'd31;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst.in_ready", in_ready, 1'b0);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk32("rst.y", y, 32'h0);
    chk32("rst.hi", hi, 32'h0);
    chk1("rst.zero", zero, 1'b0);
    chk1("rst.div0", div0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rst.in_ready_release", in_ready, 1'b1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].sh,
             vecs[i].y, vecs[i].hi, vecs[i].dz);

    // Back-to-back single-cycle ops with out_ready held high
    for (int i = 0; i < 4; i++) begin
      tp_a[i] = $urandom; tp_b[i] = $urandom;
      tp_f[i] = 5'($urandom_range(0, 14)); tp_sh[i] = 5'($urandom);
      model(tp_a[i], tp_b[i], tp_f[i], tp_sh[i], tp_y[i], tp_hi[i], rdz);
    end
    @(negedge clk);
    a = tp_a[0]; b = tp_b[0]; f = tp_f[0]; shamt = tp_sh[0]; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        a = tp_a[i+1]; b = tp_b[i+1]; f = tp_f[i+1]; shamt = tp_sh[i+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk1($sformatf("tput%0d.out_valid", i), out_valid, 1'b1);
      chk32($sformatf("tput%0d.y", i), y, tp_y[i]);
      $display("op tput%0d f=%b a=%h b=%h -> y=%h", i, tp_f[i], tp_a[i], tp_b[i], y);
    end

    // Backpressure on a divide-by-zero result, then accept on out_ready rise
    @(negedge clk);
    out_ready = 1'b0;
    a = 32'h9; b = 32'h0; f = 5'b10011; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    chk1("bp.out_valid", out_valid, 1'b1);
    chk32("bp.y", y, 32'hFFFFFFFF);
    chk32("bp.hi", hi, 32'h9);
    chk1("bp.div0", div0, 1'b1);
    a = 32'hF0; b = 32'h3C; f = 5'b00010; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("bp.hold%0d.out_valid", i), out_valid, 1'b1);
      chk1($sformatf("bp.hold%0d.in_ready", i), in_ready, 1'b0);
      chk32($sformatf("bp.hold%0d.y", i), y, 32'hFFFFFFFF);
      chk32($sformatf("bp.hold%0d.hi", i), hi, 32'h9);
      chk1($sformatf("bp.hold%0d.div0", i), div0, 1'b1);
    end
    $display("op bp.divu a=9 b=0 held 5 cycles y=%h hi=%h div0=%b", y, hi, div0);
    out_ready = 1'b1;
    #1;
    chk1("bp.in_ready_rise", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("bp.next.out_valid", out_valid, 1'b1);
    chk32("bp.next.y", y, 32'h30);
    chk32("bp.next.hi", hi, 32'h0);
    chk1("bp.next.div0", div0, 1'b0);
    $display("op bp.and a=f0 b=3c -> y=%h div0=%b", y, div0);

    // Reset pulled mid-DIVU
    @(negedge clk);
    a = 32'd100; b = 32'd7; f = 5'b10011; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk1("rstmid.busy_before", busy, 1'b1);
    chk32("rstmid.y_before", y, 32'h30);
    rst_n = 1'b0;
    #1;
    chk1("rstmid.busy", busy, 1'b0);
    chk1("rstmid.out_valid", out_valid, 1'b0);
    chk1("rstmid.in_ready", in_ready, 1'b0);
    chk32("rstmid.y", y, 32'h0);
    chk32("rstmid.hi", hi, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) seen_valid = 1'b1;
    end
    chk1("rstmid.no_stale", seen_valid, 1'b0);
    $display("op rstmid divu abandoned, idle after release");
    run_op("rstmid.sub", 32'd5, 32'd7, 5'b00001, 5'd0, 32'hFFFFFFFE, 32'h0, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = codes[$urandom_range(0, 21)];
      rsh = 5'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 5);
        2: begin ra = 32'h80000000; rb = '1; end
        3: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      model(ra, rb, rf, rsh, ry, rhi, rdz);
      run_op($sformatf("rnd%0d", i), ra, rb, rf, rsh, ry, rhi, rdz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU that succeeds the single-cycle 32-bit datapath ALU. It executes the existing logic, shift, compare and LUI operations in one cycle. It adds iterative multiply and divide that produce a HI/LO result pair. Operands enter and results leave through valid/ready handshakes, so the block sits between the decode/issue stage and writeback and can stall the pipeline while a long operation runs.

## Interface
- WIDTH, 32, datapath width; must be even and >= 8
- SHW (localparam), $clog2(WIDTH), shift-amount width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; forced 0 while rst_n=0
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- f  in  5  operation code
- shamt  in  SHW  immediate shift amount
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes result
- y  out  WIDTH  result / LO (product low half, quotient)
- hi  out  WIDTH  product high half / remainder; 0 for single-cycle ops
- zero  out  1  registered (y == 0)
- div0  out  1  registered; set when DIV/DIVU had b == 0
- busy  out  1  state is MUL or DIV

## Operation
- Single-cycle op codes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR
  - 00101 SLL b<<shamt, 00110 SRL b>>shamt, 00111 SRA signed b>>>shamt
  - 01000 SLT signed a<b -> 1/0, 01001 SLTU, 01010 NOR
  - 01011 SLLV, 01100 SRLV, 01101 SRAV; shift by a[SHW-1:0], upper bits of a ignored
  - 01110 LUI {b[WIDTH/2-1:0], WIDTH/2 zeros}
- Multi-cycle op codes: 10000 MULT signed, 10001 MULTU, 10010 DIV signed, 10011 DIVU.
- Any other code: single-cycle, y=0, hi=0, zero=1.
- Arithmetic is modulo 2^WIDTH. There is no overflow flag.
- MULT/MULTU: {hi,y} = full 2*WIDTH-bit product. Use a shift-add iteration, one partial product per cycle; signed is handled by magnitude plus final negate.
- DIV/DIVU: restoring division, one quotient bit per cycle. Signed quotient truncates toward zero; remainder takes the sign of a.
- Divide by zero: y = all ones, hi = a, div0 = 1.
- Signed DIV with a = MIN and b = -1: y = MIN, hi = 0, div0 = 0.
- div0 is cleared by every other accepted op.
- FSM states and transitions:
  - IDLE: on accept, a single-cycle op goes to DONE with its result; MULT* goes to MUL; DIV* goes to DIV.
  - MUL/DIV: count WIDTH iterations, then go to DONE with results loaded.
  - DONE: out_valid=1. With out_ready=1 and no new accept, go to IDLE. With out_ready=1 and an accept, go directly to the next op's state. With out_ready=0, hold.
- in_ready = rst_n && (state==IDLE || (state==DONE && out_ready)).
- Accept = in_valid && in_ready at a rising edge. a, b, f and shamt are latched at accept and may then change freely.

## Timing
- Reset (asynchronous assert, synchronous release by the next edge):
  - state IDLE; y, hi, zero, div0, out_valid and busy all 0.
  - The counter and internal operand/accumulator registers clear.
- Single-cycle op latency: accepted at edge k, out_valid=1 after edge k.
- MUL/DIV latency:
  - Accepted at edge k; busy=1 from edge k through edge k+WIDTH-1.
  - out_valid=1 after edge k+WIDTH (WIDTH=32: 32 cycles).
  - Latency is fixed and data-independent, including divide by zero.
- Throughput: one single-cycle op per clock when out_ready is held at 1. Back-to-back with no bubble through the DONE->next path.
- Backpressure: while out_valid && !out_ready, y, hi, zero and div0 stay stable and in_ready=0.
- Reset asserted mid-MUL/DIV: the operation is abandoned immediately, with no partial result and no out_valid.
- in_valid arriving while busy is ignored; the source must hold it until in_ready.

## Test plan
- WIDTH=32, ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid one cycle after accept, y=0, zero=1, hi=0.
- SRAV a=0x00000024 b=0x80000000 -> y=0xF8000000, since the shift uses a[4:0]=4. LUI b=0x1234ABCD -> y=0xABCD0000.
- MULT a=-3 b=7 -> busy for 32 cycles, then {hi,y}=0xFFFFFFFF_FFFFFFEB. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, y=0x00000001.
- DIV a=-7 b=2 -> y=-3 (0xFFFFFFFD), hi=-1. DIVU a=5 b=0 -> y=0xFFFFFFFF, hi=5, div0=1. DIV a=0x80000000 b=-1 -> y=0x80000000, hi=0.
- Handshake: hold out_ready=0 for 5 cycles after a result -> outputs stable and in_ready=0. Then raise out_ready with in_valid already high -> next op accepted in that same cycle.
- Pull rst_n low at iteration 10 of DIVU -> outputs clear asynchronously. After release, a fresh SUB 5-7 yields y=0xFFFFFFFE with no stale result.
